gray_to_bin_sync: RTL and testbench

- Receive-side counterpart of the team's binary-to-Gray encoder.
- Takes a Gray-coded count or pointer from another clock domain and synchronizes it into the local clock.
- Decodes it to binary through a registered stage.
- Monitors the decoded value for legal single-step increments, so async-FIFO pointers and cross-domain counters can be consumed and checked.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_to_bin_sync_sync_chain.sv | 31 +++
 rtl/gray_to_bin_sync.sv | 96 +++++++++
 tb/tb_gray_to_bin_sync.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the binary-to-Gray encoder and the Gray-to-binary receiver.
package gray_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // Prefix-XOR from the MSB down; narrower callers zero-extend, so the upper bits of the result are 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int unsigned i = 1; i < 32; i++) begin
      b[31-i] = b[32-i] ^ g[31-i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin_sync_sync_chain.sv
// Parameterised multi-bit flop chain with async reset for CDC synchronization.
module sync_chain
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_to_bin_sync.sv
// Synchronizes a foreign-domain Gray count, decodes it to binary and flags non-unit up-steps.
module gray_to_bin_sync
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             changed,
  output logic             step_err,
  output logic             err_sticky
);

  localparam int unsigned FILL_MAX = SYNC_STAGES + 1;
  localparam int unsigned FW       = $clog2(FILL_MAX + 1);

  logic [WIDTH-1:0] gray_s;
  logic [31:0]      dec_full;
  logic             unused_dec;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] bin_q, bin_d, prev_q, prev_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             valid_q, valid_d, base_q, base_d;
  logic             changed_q, changed_d, step_q, step_d, sticky_q, sticky_d;

  sync_chain #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(gray_in),
    .q_o(gray_s)
  );

  assign dec_full   = gray2bin(32'(gray_s));
  assign unused_dec = ^dec_full;

  always_comb begin
    bin_d  = dec_full[WIDTH-1:0];
    fill_d = fill_q;
    if (fill_q != FW'(FILL_MAX)) fill_d = fill_q + 1'b1;
    valid_d = (fill_d == FW'(FILL_MAX));

    diff      = bin_q - prev_q;
    prev_d    = prev_q;
    base_d    = base_q;
    changed_d = 1'b0;
    step_d    = 1'b0;
    // First valid cycle only captures the baseline; comparisons start the cycle after.
    if (valid_q) begin
      prev_d = bin_q;
      base_d = 1'b1;
      if (base_q) begin
        changed_d = (diff != '0);
        step_d    = (diff != '0) && (diff != WIDTH'(1));
      end
    end
    sticky_d = step_d | (sticky_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      prev_q    <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      base_q    <= 1'b0;
      changed_q <= 1'b0;
      step_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      prev_q    <= prev_d;
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      base_q    <= base_d;
      changed_q <= changed_d;
      step_q    <= step_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = valid_q;
  assign changed    = changed_q;
  assign step_err   = step_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_to_bin_sync.sv
// Directed bench for gray_to_bin_sync with default parameters (WIDTH=4, SYNC_STAGES=2).
module tb_gray_to_bin_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       bin_valid, changed, step_err, err_sticky;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur_bin;

  gray_to_bin_sync #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .changed   (changed),
    .step_err  (step_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bin"}, 32'(bin_out), 32'd0);
    check({tag, "_valid"}, 32'(bin_valid), 32'd0);
    check({tag, "_changed"}, 32'(changed), 32'd0);
    check({tag, "_step"}, 32'(step_err), 32'd0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
  endtask

  // Apply one Gray value and follow it through the 3-edge latency plus the registered pulse.
  task automatic step_in(input string tag, input logic [3:0] g, input logic [3:0] b,
                         input logic exp_step, input logic clr_at_pulse);
    gray_in = g;
    tick();
    tick();
    check({tag, "_hold"}, 32'(bin_out), 32'(cur_bin));
    tick();
    check({tag, "_bin"}, 32'(bin_out), 32'(b));
    check({tag, "_nopulse"}, 32'(changed), 32'd0);
    if (clr_at_pulse) clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check({tag, "_changed"}, 32'(changed), 32'd1);
    check({tag, "_step"}, 32'(step_err), 32'(exp_step));
    cur_bin = b;
  endtask

  logic [3:0] gray_tab [16];
  initial begin
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  end

  initial begin
    rst     = 1'b1;
    gray_in = 4'b0000;
    clr_err = 1'b0;
    cur_bin = 4'd0;
    #12;
    check_zero("rst");
    tick();
    rst = 1'b0;

    // Pipeline fill
    tick();
    check("fill1_valid", 32'(bin_valid), 32'd0);
    tick();
    check("fill2_valid", 32'(bin_valid), 32'd0);
    tick();
    check("fill3_valid", 32'(bin_valid), 32'd1);
    check("fill3_bin", 32'(bin_out), 32'd0);
    tick();
    tick();
    check("fill_changed", 32'(changed), 32'd0);
    check("fill_step", 32'(step_err), 32'd0);

    // Count 1..15 then wrap to 0
    for (int unsigned i = 1; i < 16; i++) begin
      step_in($sformatf("cnt%0d", i), gray_tab[i], 4'(i), 1'b0, 1'b0);
    end
    step_in("wrap", 4'b0000, 4'd0, 1'b0, 1'b0);
    check("wrap_sticky", 32'(err_sticky), 32'd0);

    // Illegal jump 1 -> 4
    step_in("pre_jump", 4'b0001, 4'd1, 1'b0, 1'b0);
    step_in("jump", 4'b0110, 4'd4, 1'b1, 1'b0);
    tick();
    check("jump_pulse_end", 32'(step_err), 32'd0);
    check("jump_sticky", 32'(err_sticky), 32'd1);
    tick();
    check("jump_sticky_hold", 32'(err_sticky), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("jump_clr", 32'(err_sticky), 32'd0);

    // Decrement 4 -> 3 is an error; clear it
    step_in("dec", 4'b0010, 4'd3, 1'b1, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("dec_clr", 32'(err_sticky), 32'd0);

    // Set wins over clear: 3 -> 0 with clr_err on the same edge
    step_in("setwin", 4'b0000, 4'd0, 1'b1, 1'b1);
    check("setwin_sticky", 32'(err_sticky), 32'd1);
    tick();
    check("setwin_hold", 32'(err_sticky), 32'd1);
    check("setwin_pulse_end", 32'(step_err), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("setwin_clr", 32'(err_sticky), 32'd0);

    // Reach 5, then async reset mid-run
    for (int unsigned i = 1; i < 6; i++) begin
      step_in($sformatf("pre_rst%0d", i), gray_tab[i], 4'(i), 1'b0, 1'b0);
    end
    tick();
    #3;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    cur_bin = 4'd0;
    tick();
    check("refill1_valid", 32'(bin_valid), 32'd0);
    tick();
    check("refill2_valid", 32'(bin_valid), 32'd0);
    check("refill2_bin", 32'(bin_out), 32'd0);
    tick();
    check("refill3_valid", 32'(bin_valid), 32'd1);
    check("refill3_bin", 32'(bin_out), 32'd5);
    tick();
    tick();
    check("refill_step", 32'(step_err), 32'd0);
    check("refill_changed", 32'(changed), 32'd0);
    tick();
    check("refill_step2", 32'(step_err), 32'd0);
    check("refill_sticky", 32'(err_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
